// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage plus IF/ID pipeline register.
// Keeps the fetch PC and requests one instruction word at a time over a
// req/ready handshake. A three-state controller handles the fetch:
//   REQ     - request outstanding at pc_f
//   HOLD    - a word arrived while decode was stalled; it is parked in hold_q
//   DISCARD - a redirect arrived while a request was in flight; the stale
//             response is awaited and dropped before fetching the target
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [6:0]      op_d,
  output logic [2:0]      funct3_d,
  output logic            funct7b5_d
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [31:0]     hold_q, hold_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;

  // Fetch-side helpers: whether a word is handed to decode this cycle, and which word.
  logic            load;
  logic [31:0]     load_word;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_f_q + XLEN'(4);

  // Next-state, fetch PC and IF/ID update; every target starts from its held value.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    hold_d       = hold_q;
    tgt_d        = tgt_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    load         = 1'b0;
    load_word    = hold_q;

    case (state_q)
      S_REQ: begin
        if (pc_src_e) begin
          if (imem_ready) begin
            // Response belongs to the wrong path: drop it and fetch the target next.
            pc_f_d = pc_target_e;
          end else begin
            // Address must stay put until the in-flight request completes.
            tgt_d   = pc_target_e;
            state_d = S_DISCARD;
          end
        end else if (imem_ready) begin
          if (!stall_d) begin
            load      = 1'b1;
            load_word = imem_rdata;
            pc_f_d    = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (pc_src_e) begin
          pc_f_d  = pc_target_e;
          state_d = S_REQ;
        end else if (!stall_d) begin
          load      = 1'b1;
          load_word = hold_q;
          pc_f_d    = pc_plus4;
          state_d   = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_ready) begin
          // A redirect arriving in the same cycle is newer than tgt_q.
          pc_f_d  = pc_src_e ? pc_target_e : tgt_q;
          state_d = S_REQ;
        end else if (pc_src_e) begin
          tgt_d = pc_target_e;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // IF/ID: kill beats stall, stall beats load; a bubble keeps the old PCs.
    if (pc_src_e || flush_d) begin
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end else if (!stall_d) begin
      if (load) begin
        ifid_instr_d = load_word;
        ifid_pc_d    = pc_f_q;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_f_q       <= RESET_PC;
      hold_q       <= '0;
      tgt_q        <= '0;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      hold_q       <= hold_d;
      tgt_q        <= tgt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // No request while parked in HOLD or while reset is held.
  assign imem_req   = (state_q != S_HOLD) && !reset;
  assign imem_addr  = pc_f_q;

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;

  // Decode fields straight from the IF/ID instruction.
  assign op_d       = ifid_instr_q[6:0];
  assign funct3_d   = ifid_instr_q[14:12];
  assign funct7b5_d = ifid_instr_q[30];

endmodule
